// File: rtl/rf_alu_sequencer_if.sv
// Instruction handshake between the instruction source and the RF_ALU sequencer.
interface rf_alu_sequencer_if;
    logic        instr_valid;
    logic [31:0] instr;
    logic        instr_ready;

    modport master (output instr_valid, output instr, input instr_ready);
    modport slave  (input instr_valid, input instr, output instr_ready);
endinterface

// File: rtl/rf_alu_sequencer.sv
// Multi-cycle controller: decodes LEGv8 R-type/CBZ and drives RF_ALU through
// read/execute/write-back, reporting retire, branch outcome and illegal opcodes.
module rf_alu_sequencer (
    input  logic                 clock,
    input  logic                 resetn,
    rf_alu_sequencer_if.slave    bus,
    input  logic                 zero,
    output logic [1:0]           ALUOp,
    output logic [10:0]          OpcodeField,
    output logic [4:0]           Read1,
    output logic [4:0]           Read2,
    output logic [4:0]           WriteReg,
    output logic                 RegWrite,
    output logic                 done,
    output logic                 branch_taken,
    output logic                 illegal,
    output logic [15:0]          retire_count
);
    localparam int unsigned OP_W  = 11;
    localparam int unsigned REG_W = 5;
    localparam int unsigned CNT_W = 16;

    localparam logic [OP_W-1:0] OP_ADD = 11'b10001011000;
    localparam logic [OP_W-1:0] OP_SUB = 11'b11001011000;
    localparam logic [OP_W-1:0] OP_AND = 11'b10001010000;
    localparam logic [OP_W-1:0] OP_ORR = 11'b10101010000;
    localparam logic [7:0]      OP_CBZ = 8'b10110100;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB} state_t;
    typedef enum logic [1:0] {C_RTYPE, C_CBZ, C_ILLEGAL} iclass_t;

    state_t            r_state, w_state_nxt;
    iclass_t           r_class, w_class_nxt;
    logic [1:0]        r_alu_op, w_alu_op_nxt;
    logic [OP_W-1:0]   r_opcode, w_opcode_nxt;
    logic [REG_W-1:0]  r_read1, w_read1_nxt;
    logic [REG_W-1:0]  r_read2, w_read2_nxt;
    logic [REG_W-1:0]  r_write_reg, w_write_reg_nxt;
    logic              r_reg_write, w_reg_write_nxt;
    logic              r_done, w_done_nxt;
    logic              r_branch, w_branch_nxt;
    logic              r_illegal, w_illegal_nxt;
    logic [CNT_W-1:0]  r_retire_count, w_retire_count_nxt;

    logic              w_accept;
    logic              w_is_rtype;
    logic              w_is_cbz;
    logic              w_retire;

    assign bus.instr_ready = (r_state == S_IDLE) && resetn;
    assign w_accept        = bus.instr_valid && bus.instr_ready;

    assign w_is_rtype = (bus.instr[31:21] == OP_ADD) || (bus.instr[31:21] == OP_SUB) ||
                        (bus.instr[31:21] == OP_AND) || (bus.instr[31:21] == OP_ORR);
    assign w_is_cbz   = (bus.instr[31:24] == OP_CBZ);

    // Next-state, field latch and retire bookkeeping
    always_comb begin
        w_state_nxt        = r_state;
        w_class_nxt        = r_class;
        w_alu_op_nxt       = r_alu_op;
        w_opcode_nxt       = r_opcode;
        w_read1_nxt        = r_read1;
        w_read2_nxt        = r_read2;
        w_write_reg_nxt    = r_write_reg;
        w_reg_write_nxt    = 1'b0;
        w_done_nxt         = 1'b0;
        w_branch_nxt       = r_branch;
        w_illegal_nxt      = r_illegal;
        w_retire_count_nxt = r_retire_count;
        w_retire           = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_EXEC;
                    if (w_is_rtype) begin
                        w_class_nxt     = C_RTYPE;
                        w_alu_op_nxt    = 2'b10;
                        w_opcode_nxt    = bus.instr[31:21];
                        w_read1_nxt     = bus.instr[9:5];
                        w_read2_nxt     = bus.instr[20:16];
                        w_write_reg_nxt = bus.instr[4:0];
                    end else if (w_is_cbz) begin
                        w_class_nxt     = C_CBZ;
                        w_alu_op_nxt    = 2'b01;
                        w_opcode_nxt    = bus.instr[31:21];
                        w_read1_nxt     = REG_W'(0);
                        w_read2_nxt     = bus.instr[4:0];
                        w_write_reg_nxt = REG_W'(0);
                    end else begin
                        w_class_nxt     = C_ILLEGAL;
                        w_alu_op_nxt    = 2'b00;
                        w_opcode_nxt    = OP_W'(0);
                        w_read1_nxt     = REG_W'(0);
                        w_read2_nxt     = REG_W'(0);
                        w_write_reg_nxt = REG_W'(0);
                    end
                end
            end
            S_EXEC: begin
                // XZR destination skips write-back entirely
                if ((r_class == C_RTYPE) && (r_write_reg != REG_W'(31))) begin
                    w_state_nxt     = S_WB;
                    w_reg_write_nxt = 1'b1;
                end else begin
                    w_state_nxt = S_IDLE;
                    w_retire    = 1'b1;
                end
            end
            S_WB: begin
                w_state_nxt = S_IDLE;
                w_retire    = 1'b1;
            end
            default: w_state_nxt = S_IDLE;
        endcase

        if (w_retire) begin
            w_done_nxt         = 1'b1;
            w_retire_count_nxt = r_retire_count + CNT_W'(1);
            w_illegal_nxt      = (r_class == C_ILLEGAL);
            w_branch_nxt       = (r_class == C_CBZ) && zero;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state        <= S_IDLE;
            r_class        <= C_ILLEGAL;
            r_alu_op       <= 2'b00;
            r_opcode       <= OP_W'(0);
            r_read1        <= REG_W'(0);
            r_read2        <= REG_W'(0);
            r_write_reg    <= REG_W'(0);
            r_reg_write    <= 1'b0;
            r_done         <= 1'b0;
            r_branch       <= 1'b0;
            r_illegal      <= 1'b0;
            r_retire_count <= CNT_W'(0);
        end else begin
            r_state        <= w_state_nxt;
            r_class        <= w_class_nxt;
            r_alu_op       <= w_alu_op_nxt;
            r_opcode       <= w_opcode_nxt;
            r_read1        <= w_read1_nxt;
            r_read2        <= w_read2_nxt;
            r_write_reg    <= w_write_reg_nxt;
            r_reg_write    <= w_reg_write_nxt;
            r_done         <= w_done_nxt;
            r_branch       <= w_branch_nxt;
            r_illegal      <= w_illegal_nxt;
            r_retire_count <= w_retire_count_nxt;
        end
    end

    assign ALUOp        = r_alu_op;
    assign OpcodeField  = r_opcode;
    assign Read1        = r_read1;
    assign Read2        = r_read2;
    assign WriteReg     = r_write_reg;
    // Gate with reset so a WB write is dropped on the very edge reset is sampled
    assign RegWrite     = r_reg_write && resetn;
    assign done         = r_done;
    assign branch_taken = r_branch;
    assign illegal      = r_illegal;
    assign retire_count = r_retire_count;
endmodule
